flag_branch_unit: RTL
=====================

FLAG_BRANCH_UNIT -- requirements
Module: flag_branch_unit

Interface
REQ-001 SHALL have parameter RESET_FLAGS, default 3'b000, meaning the {Z,V,N} value loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ex_valid  input  1  an ALU result is present this cycle.
REQ-005 SHALL have port ex_opcode  input  3  ALU opcode of that result (ADD 000, SUB 001, XOR 010, RED 011, SLL 100, SRA 101, ROR 110, PADDSB 111).
REQ-006 SHALL have port alu_out  input  16  ALU result, already saturated for ADD/SUB.
REQ-007 SHALL have port alu_ovfl  input  1  signed overflow of the ADD/SUB, before saturation.
REQ-008 SHALL have port stall  input  1  pipeline hold.
REQ-009 SHALL have port flush  input  1  kill the current EX op and any pending branch.
REQ-010 SHALL have port br_valid  input  1  branch request this cycle.
REQ-011 SHALL have port br_cond  input  3  branch condition code.
REQ-012 SHALL have port flags  output  3  registered {Z,V,N}.
REQ-013 SHALL have port br_done  output  1  one-cycle pulse: branch resolved.
REQ-014 SHALL have port br_taken  output  1  resolution result, valid only with br_done.
REQ-015 SHALL have port br_busy  output  1  a branch is waiting on stall.

Function
REQ-016 Flag write SHALL occur at the clock edge only when ex_valid=1, stall=0 and flush=0.
REQ-017 ADD/SUB writes SHALL set Z=(alu_out==0), V=alu_ovfl and N=alu_out[15] (0x7FFF gives N=0; 0x8000 gives N=1).
REQ-018 XOR/SLL/SRA/ROR writes SHALL update Z only; V and N hold.
REQ-019 RED/PADDSB SHALL leave all flags unchanged.
REQ-020 Effective flags SHALL be the next-state flags when a flag write occurs this cycle, and the registered flags otherwise.
REQ-021 Condition codes SHALL be evaluated on the effective flags as follows:
- 000 NEQ: Z=0
- 001 EQ: Z=1
- 010 GT: Z=0 and N=0
- 011 LT: N=1
- 100 GTE: Z=1, or Z=0 and N=0
- 101 LTE: N=1 or Z=1
- 110 OVFL: V=1
- 111 always taken
REQ-022 The FSM SHALL have states IDLE, PEND and RESOLVE.
REQ-023 IDLE SHALL go to RESOLVE, latching br_cond and the evaluation, when br_valid=1, flush=0 and stall=0; it SHALL go to PEND, latching br_cond, when br_valid=1, flush=0 and stall=1.
REQ-024 br_valid together with flush in IDLE SHALL be dropped.
REQ-025 PEND SHALL hold while stall=1, with br_busy=1.
- When stall=0: evaluate on the effective flags that cycle and go to RESOLVE.
- flush=1: go to IDLE with no br_done.
- br_valid: ignored.
REQ-026 RESOLVE SHALL assert br_done=1 and br_taken=latched result for exactly one cycle.
- Next state IDLE, or RESOLVE/PEND directly if a new branch is accepted that same cycle, so back-to-back branches are possible.
- flush during RESOLVE does not cancel that output.
REQ-027 Latency from an unstalled branch accepted at cycle N SHALL be br_done in cycle N+1.
REQ-028 br_taken SHALL be 0 whenever br_done=0.
REQ-029 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-030 rst_n=0 at a clock edge SHALL set flags=RESET_FLAGS, state=IDLE and br_done=br_taken=br_busy=0.
REQ-031 Reset SHALL dominate ex_valid, br_valid, stall and flush, including reset asserted mid-PEND or mid-RESOLVE.

Structure
REQ-032 ALU opcode constants, condition-code constants, FSM state encodings and Z/V/N bit indices SHALL live in one shared package, also used by the ALU and the decoder.
REQ-033 Condition evaluation SHALL be a combinational sub-module br_cond_eval (inputs cond[2:0] and flags[2:0], output taken).

Verification
REQ-034 ADD with alu_out=0x0000, ovfl=0 -> flags=3'b100 next cycle; then SUB with alu_out=0x8000, ovfl=1 -> flags=3'b011.
REQ-035 Starting from flags=3'b011: XOR with alu_out=0x0000 -> flags=3'b111; then RED with 0x0005 -> flags stay 3'b111; then any write with stall=1 or flush=1 -> flags unchanged.
REQ-036 Starting from flags=000: same cycle ex_valid ADD with alu_out=0 and br_valid with cond=001 -> next cycle br_done=1, br_taken=1 (bypass).
REQ-037 br_valid with cond=110 and stall=1 for 3 cycles -> br_busy=1 for those 3 cycles, br_done one cycle after stall drops; repeated with flush in the 2nd cycle -> br_busy falls and no br_done.
REQ-038 Condition checks:
- cond=111 -> taken for every flag value.
- cond=100 with flags Z=0, N=1 -> br_done=1, br_taken=0.
- Two unstalled branches on consecutive cycles -> two consecutive br_done pulses.
REQ-039 rst_n=0 during PEND with flags=3'b111 -> after the edge flags=000, br_busy=0, br_done=0, and no br_done follows.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit_pkg
// Purpose  : Shared ALU opcodes, condition codes, flag indices, branch states
// Revision : 1.0
// ============================================================================
package flag_branch_unit_pkg;

  localparam logic [2:0] C_OP_ADD    = 3'b000;
  localparam logic [2:0] C_OP_SUB    = 3'b001;
  localparam logic [2:0] C_OP_XOR    = 3'b010;
  localparam logic [2:0] C_OP_RED    = 3'b011;
  localparam logic [2:0] C_OP_SLL    = 3'b100;
  localparam logic [2:0] C_OP_SRA    = 3'b101;
  localparam logic [2:0] C_OP_ROR    = 3'b110;
  localparam logic [2:0] C_OP_PADDSB = 3'b111;

  localparam logic [2:0] C_CC_NEQ  = 3'b000;
  localparam logic [2:0] C_CC_EQ   = 3'b001;
  localparam logic [2:0] C_CC_GT   = 3'b010;
  localparam logic [2:0] C_CC_LT   = 3'b011;
  localparam logic [2:0] C_CC_GTE  = 3'b100;
  localparam logic [2:0] C_CC_LTE  = 3'b101;
  localparam logic [2:0] C_CC_OVFL = 3'b110;
  localparam logic [2:0] C_CC_UNC  = 3'b111;

  // Flag vector layout is {Z,V,N}
  localparam int C_FLAG_Z = 2;
  localparam int C_FLAG_V = 1;
  localparam int C_FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_RESOLVE = 2'd2
  } br_state_t;

  function automatic logic op_writes_zvn(input logic [2:0] op);
    return (op == C_OP_ADD) || (op == C_OP_SUB);
  endfunction

  function automatic logic op_writes_z_only(input logic [2:0] op);
    return (op == C_OP_XOR) || (op == C_OP_SLL) ||
           (op == C_OP_SRA) || (op == C_OP_ROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/flag_branch_unit_cond.sv
`default_nettype none
// ============================================================================
// Module   : br_cond_eval
// Purpose  : Combinational branch condition evaluation on {Z,V,N}
// Revision : 1.0
// ============================================================================
module br_cond_eval
  import flag_branch_unit_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic w_z;
  logic w_v;
  logic w_n;

  assign w_z = flags[C_FLAG_Z];
  assign w_v = flags[C_FLAG_V];
  assign w_n = flags[C_FLAG_N];

  always_comb begin
    taken = 1'b0;
    case (cond)
      C_CC_NEQ:  taken = ~w_z;
      C_CC_EQ:   taken = w_z;
      C_CC_GT:   taken = ~w_z & ~w_n;
      C_CC_LT:   taken = w_n;
      C_CC_GTE:  taken = w_z | (~w_z & ~w_n);
      C_CC_LTE:  taken = w_n | w_z;
      C_CC_OVFL: taken = w_v;
      C_CC_UNC:  taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/flag_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_branch_unit
// Purpose  : ALU flag register with same-cycle bypass and stall-aware branch
//            resolution FSM; every output is registered
// Revision : 1.0
// ============================================================================
module flag_branch_unit
  import flag_branch_unit_pkg::*;
#(
  parameter logic [2:0] RESET_FLAGS = 3'b000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_ovfl,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  output logic [2:0]  flags,
  output logic        br_done,
  output logic        br_taken,
  output logic        br_busy
);

  logic [2:0] r_flags;
  logic [2:0] w_flags_nxt;
  logic [2:0] w_flags_eff;
  logic       w_flag_we;
  logic       w_result_zero;

  br_state_t  r_state;
  logic [2:0] r_cond;
  logic       r_br_done;
  logic       r_br_taken;
  logic       r_br_busy;
  logic [2:0] w_eval_cond;
  logic       w_taken;
  logic       w_accept;

  assign w_flag_we     = ex_valid & ~stall & ~flush;
  assign w_result_zero = (alu_out == 16'h0000);

  always_comb begin
    w_flags_nxt = r_flags;
    if (op_writes_zvn(ex_opcode)) begin
      w_flags_nxt[C_FLAG_Z] = w_result_zero;
      w_flags_nxt[C_FLAG_V] = alu_ovfl;
      w_flags_nxt[C_FLAG_N] = alu_out[15];
    end else if (op_writes_z_only(ex_opcode)) begin
      w_flags_nxt[C_FLAG_Z] = w_result_zero;
    end
  end

  // Branches see the flags being written this cycle, not last cycle's value
  assign w_flags_eff = w_flag_we ? w_flags_nxt : r_flags;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flags <= RESET_FLAGS;
    end else if (w_flag_we) begin
      r_flags <= w_flags_nxt;
    end
  end

  // A parked branch is evaluated with its own latched condition code
  assign w_eval_cond = (r_state == ST_PEND) ? r_cond : br_cond;
  assign w_accept    = br_valid & ~flush;

  br_cond_eval u_cond_eval (
    .cond  (w_eval_cond),
    .flags (w_flags_eff),
    .taken (w_taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cond     <= 3'b000;
      r_br_done  <= 1'b0;
      r_br_taken <= 1'b0;
      r_br_busy  <= 1'b0;
    end else begin
      r_br_done  <= 1'b0;
      r_br_taken <= 1'b0;
      r_br_busy  <= 1'b0;
      case (r_state)
        ST_PEND: begin
          if (flush) begin
            r_state <= ST_IDLE;
          end else if (stall) begin
            r_state   <= ST_PEND;
            r_br_busy <= 1'b1;
          end else begin
            r_state    <= ST_RESOLVE;
            r_br_done  <= 1'b1;
            r_br_taken <= w_taken;
          end
        end
        // RESOLVE is reporting its result this cycle and can accept anew
        default: begin
          if (w_accept) begin
            r_cond <= br_cond;
            if (stall) begin
              r_state   <= ST_PEND;
              r_br_busy <= 1'b1;
            end else begin
              r_state    <= ST_RESOLVE;
              r_br_done  <= 1'b1;
              r_br_taken <= w_taken;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign flags    = r_flags;
  assign br_done  = r_br_done;
  assign br_taken = r_br_taken;
  assign br_busy  = r_br_busy;

endmodule
`default_nettype wire
